// File: rtl/vga_write_arbiter.sv
// -----------------------------------------------------------------------------
// vga_write_arbiter
//
// Shares one VGA adapter pixel-write port between three requesters and an
// internal full-screen clear sweep.
//
// After reset (and whenever clear_req is seen while idle) the block sweeps
// every visible pixel in raster order, writing colour 000. Otherwise it grants
// the port round-robin to requesters asserting req. Each grant lasts until the
// owner drops req or until MAX_BURST granted cycles have elapsed, whichever
// comes first. At least one idle cycle separates consecutive owners.
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   req[2:0]    per-requester request, held high for the whole burst
//   x_in[23:0]  requester i x coordinate in bits [8i+7:8i]
//   y_in[20:0]  requester i y coordinate in bits [7i+6:7i]
//   colour_in   requester i colour in bits [3i+2:3i]
//   we_in[2:0]  per-requester pixel write strobe
//   clear_req   start a full-screen clear (honoured only while idle)
//   grant[2:0]  registered one-hot grant, 000 when nobody owns the port
//   x_out/y_out/colour/writeEn  registered pixel write to the VGA adapter
//   clear_busy  high while the clear sweep runs
// -----------------------------------------------------------------------------
module vga_write_arbiter #(
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int MAX_BURST = 432
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [23:0] x_in,
  input  logic [20:0] y_in,
  input  logic [8:0]  colour_in,
  input  logic [2:0]  we_in,
  input  logic        clear_req,
  output logic [2:0]  grant,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  colour,
  output logic        writeEn,
  output logic        clear_busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [7:0]       LAST_X    = 8'(SCREEN_W - 1);
  localparam logic [6:0]       LAST_Y    = 7'(SCREEN_H - 1);
  localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Per-requester views of the packed input buses
  // ---------------------------------------------------------------------------
  logic [7:0] x_arr      [3];
  logic [6:0] y_arr      [3];
  logic [2:0] colour_arr [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_unpack
      assign x_arr[gi]      = x_in[8*gi +: 8];
      assign y_arr[gi]      = y_in[7*gi +: 7];
      assign colour_arr[gi] = colour_in[3*gi +: 3];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q,      state_d;
  logic [7:0]       cx_q,         cx_d;          // clear sweep column
  logic [6:0]       cy_q,         cy_d;          // clear sweep row
  logic             clear_last_q, clear_last_d;  // final pixel already issued
  logic [1:0]       owner_q,      owner_d;
  logic [1:0]       last_owner_q, last_owner_d;
  logic [CNT_W-1:0] burst_q,      burst_d;       // granted cycles minus one
  logic [2:0]       grant_q,      grant_d;
  logic [7:0]       x_out_q,      x_out_d;
  logic [6:0]       y_out_q,      y_out_d;
  logic [2:0]       colour_q,     colour_d;
  logic             we_q,         we_d;
  logic             clear_busy_q, clear_busy_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick: search (last_owner+1), (last_owner+2), last_owner
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] rr_next(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  logic [1:0] cand1, cand2, sel;
  logic       sel_valid;

  always_comb begin
    cand1     = rr_next(last_owner_q);
    cand2     = rr_next(cand1);
    sel       = last_owner_q;
    sel_valid = 1'b1;
    if (req[cand1]) begin
      sel = cand1;
    end else if (req[cand2]) begin
      sel = cand2;
    end else if (req[last_owner_q]) begin
      sel = last_owner_q;
    end else begin
      sel_valid = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Owner's pixel and its visibility
  // ---------------------------------------------------------------------------
  logic [7:0]  own_x;
  logic [6:0]  own_y;
  logic [2:0]  own_colour;
  logic        own_we;
  logic        own_req;
  logic        in_bounds;

  always_comb begin
    own_x      = x_arr[owner_q];
    own_y      = y_arr[owner_q];
    own_colour = colour_arr[owner_q];
    own_we     = we_in[owner_q];
    own_req    = req[owner_q];
    in_bounds  = (32'(own_x) < 32'(SCREEN_W)) && (32'(own_y) < 32'(SCREEN_H));
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    clear_last_d = clear_last_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    grant_d      = 3'b000;
    x_out_d      = 8'd0;
    y_out_d      = 7'd0;
    colour_d     = 3'b000;
    we_d         = 1'b0;
    clear_busy_d = 1'b0;

    case (state_q)
      S_CLEAR: begin
        if (clear_last_q) begin
          // Final pixel went out on the previous edge; outputs drop to idle now
          state_d      = S_IDLE;
          clear_last_d = 1'b0;
          cx_d         = 8'd0;
          cy_d         = 7'd0;
        end else begin
          clear_busy_d = 1'b1;
          x_out_d      = cx_q;
          y_out_d      = cy_q;
          we_d         = 1'b1;
          if (cx_q == LAST_X) begin
            cx_d = 8'd0;
            if (cy_q == LAST_Y) begin
              cy_d         = 7'd0;
              clear_last_d = 1'b1;
            end else begin
              cy_d = cy_q + 7'd1;
            end
          end else begin
            cx_d = cx_q + 8'd1;
          end
        end
      end

      S_IDLE: begin
        if (clear_req) begin
          // Clear wins over any simultaneous request
          state_d      = S_CLEAR;
          cx_d         = 8'd0;
          cy_d         = 7'd0;
          clear_last_d = 1'b0;
          clear_busy_d = 1'b1;
        end else if (sel_valid) begin
          state_d = S_GRANT;
          owner_d = sel;
          grant_d = 3'b001 << sel;
          burst_d = '0;
        end
      end

      S_GRANT: begin
        if (!own_req || (burst_q == BURST_END)) begin
          // Owner released the port or used its full burst: back to idle,
          // and the round-robin pointer moves past this owner.
          state_d      = S_IDLE;
          last_owner_d = owner_q;
        end else begin
          grant_d  = grant_q;
          burst_d  = burst_q + 1'b1;
          x_out_d  = own_x;
          y_out_d  = own_y;
          colour_d = own_colour;
          we_d     = own_we & own_req & in_bounds;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      cx_q         <= 8'd0;
      cy_q         <= 7'd0;
      clear_last_q <= 1'b0;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd2;
      burst_q      <= '0;
      grant_q      <= 3'b000;
      x_out_q      <= 8'd0;
      y_out_q      <= 7'd0;
      colour_q     <= 3'b000;
      we_q         <= 1'b0;
      clear_busy_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      clear_last_q <= clear_last_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      grant_q      <= grant_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      colour_q     <= colour_d;
      we_q         <= we_d;
      clear_busy_q <= clear_busy_d;
    end
  end

  assign grant      = grant_q;
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour     = colour_q;
  assign writeEn    = we_q;
  assign clear_busy = clear_busy_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_write_arbiter
//
// Inputs are driven and outputs sampled on the falling clock edge. Expected
// values come from a small reference model: raster arithmetic for the clear
// sweep, a round-robin pointer for owner selection and a bounds formula for
// the pixel path.
// -----------------------------------------------------------------------------
module tb_vga_write_arbiter;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int BURST = 432;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] x_in;
  logic [20:0] y_in;
  logic [8:0]  colour_in;
  logic [2:0]  we_in;
  logic        clear_req;
  logic [2:0]  grant;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour;
  logic        writeEn;
  logic        clear_busy;

  int checks = 0;
  int errors = 0;
  int model_last = 2;   // model's round-robin pointer

  vga_write_arbiter #(.SCREEN_W(W), .SCREEN_H(H), .MAX_BURST(BURST)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .we_in      (we_in),
    .clear_req  (clear_req),
    .grant      (grant),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour     (colour),
    .writeEn    (writeEn),
    .clear_busy (clear_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int rr_pick(input int last, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k) % 3;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Full clear sweep: first pixel within a few cycles, then W*H consecutive
  // raster-order writes of colour 000, then writeEn and clear_busy low.
  task automatic check_sweep(input string tag);
    int waited;
    waited = 0;
    while (writeEn !== 1'b1 && waited < 4) begin
      tick();
      waited++;
    end
    checks++;
    if (writeEn !== 1'b1) begin
      $display("FAIL %s_start: writeEn=%b after %0d cycles, required 1", tag, writeEn, waited);
      errors++;
      return;
    end
    for (int i = 0; i < W * H; i++) begin
      int ex, ey;
      if (i > 0) tick();
      ex = i % W;
      ey = i / W;
      checks++;
      if (writeEn !== 1'b1 || x_out !== 8'(ex) || y_out !== 7'(ey) || colour !== 3'b000 ||
          clear_busy !== 1'b1 || grant !== 3'b000) begin
        $display("FAIL %s_pixel%0d: we=%b x=%0d y=%0d col=%b busy=%b grant=%b, required we=1 x=%0d y=%0d col=000 busy=1 grant=000",
                 tag, i, writeEn, x_out, y_out, colour, clear_busy, grant, ex, ey);
        errors++;
        break;
      end
    end
    tick();
    checks++;
    if (writeEn !== 1'b0 || clear_busy !== 1'b0) begin
      $display("FAIL %s_end: we=%b busy=%b, required we=0 busy=0", tag, writeEn, clear_busy);
      errors++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 3'b000; x_in = '0; y_in = '0; colour_in = '0;
    we_in = 3'b000; clear_req = 1'b0;
    repeat (3) tick();
    checks++;
    if (grant !== 3'b000) begin
      $display("FAIL reset_grant: got %b required 000", grant); errors++;
    end
    checks++;
    if (writeEn !== 1'b0 || x_out !== 8'd0 || y_out !== 7'd0 || colour !== 3'b000) begin
      $display("FAIL reset_pixel: we=%b x=%0d y=%0d col=%b required all 0", writeEn, x_out, y_out, colour);
      errors++;
    end
    checks++;
    if (clear_busy !== 1'b1) begin
      $display("FAIL reset_busy: got %b required 1", clear_busy); errors++;
    end
  endtask

  task automatic test_clear_sweep();
    reset = 1'b0;
    check_sweep("sweep_after_reset");
    model_last = 2;
  endtask

  // req=111 held: owners rotate 0,1,2,0, each preempted after BURST cycles,
  // one idle cycle between owners.
  task automatic test_round_robin();
    int waited, len, gap, exp_owner;
    logic [2:0] expv;
    req = 3'b111;
    waited = 0;
    tick();
    while (grant === 3'b000 && waited < 4) begin
      tick();
      waited++;
    end
    for (int k = 0; k < 4; k++) begin
      exp_owner = rr_pick(model_last, 3'b111);
      expv = 3'(1 << exp_owner);
      checks++;
      if (grant !== expv) begin
        $display("FAIL rr_order%0d: grant=%b required %b", k, grant, expv); errors++;
      end
      if (k == 3) begin
        req = 3'b000;
        tick();
        checks++;
        if (grant !== 3'b000) begin
          $display("FAIL rr_release: grant=%b required 000", grant); errors++;
        end
        model_last = exp_owner;
        break;
      end
      len = 1;
      while (len < 1000) begin
        tick();
        if (grant === expv) len++;
        else break;
      end
      checks++;
      if (len != BURST) begin
        $display("FAIL rr_len%0d: grant lasted %0d cycles, required %0d", k, len, BURST); errors++;
      end
      model_last = exp_owner;
      gap = 0;
      while (grant === 3'b000 && gap < 10) begin
        gap++;
        tick();
      end
      checks++;
      if (gap != 1) begin
        $display("FAIL rr_gap%0d: idle gap %0d cycles, required 1", k, gap); errors++;
      end
    end
  endtask

  // Random request masks and random pixel traffic on all requesters; only
  // the owner's pixel may reach the outputs, one cycle later.
  task automatic test_random_pixels();
    for (int it = 0; it < 12; it++) begin
      logic [2:0] mask, expv;
      int exp_owner, n;
      mask = 3'($urandom_range(1, 7));
      req = mask;
      tick();
      exp_owner = rr_pick(model_last, mask);
      expv = 3'(1 << exp_owner);
      checks++;
      if (grant !== expv || writeEn !== 1'b0) begin
        $display("FAIL rand_grant%0d: req=%b grant=%b we=%b required grant=%b we=0",
                 it, mask, grant, writeEn, expv);
        errors++;
      end
      n = $urandom_range(3, 20);
      for (int j = 0; j < n; j++) begin
        int ex, ey, ec;
        logic ew;
        for (int r = 0; r < 3; r++) begin
          x_in[8*r +: 8]      = 8'($urandom_range(0, 200));
          y_in[7*r +: 7]      = 7'($urandom_range(0, 127));
          colour_in[3*r +: 3] = 3'($urandom_range(0, 7));
          we_in[r]            = 1'($urandom_range(0, 1));
        end
        ex = int'(x_in[8*exp_owner +: 8]);
        ey = int'(y_in[7*exp_owner +: 7]);
        ec = int'(colour_in[3*exp_owner +: 3]);
        ew = we_in[exp_owner] && (ex < W) && (ey < H);
        tick();
        checks++;
        if (x_out !== 8'(ex) || y_out !== 7'(ey) || colour !== 3'(ec) || writeEn !== ew || grant !== expv) begin
          $display("FAIL rand_pixel%0d_%0d: x=%0d y=%0d col=%0d we=%b grant=%b required x=%0d y=%0d col=%0d we=%b grant=%b",
                   it, j, x_out, y_out, colour, writeEn, grant, ex, ey, ec, ew, expv);
          errors++;
        end
      end
      req = 3'b000;
      we_in = 3'b000;
      tick();
      checks++;
      if (grant !== 3'b000 || writeEn !== 1'b0) begin
        $display("FAIL rand_release%0d: grant=%b we=%b required 000/0", it, grant, writeEn); errors++;
      end
      model_last = exp_owner;
    end
  endtask

  // Owner 1 writes off-screen then on-screen; clear_req during a grant is ignored.
  task automatic test_bounds();
    req = 3'b010;
    tick();
    checks++;
    if (grant !== 3'b010) begin
      $display("FAIL bounds_grant: grant=%b required 010", grant); errors++;
    end
    x_in = {8'd3, 8'd165, 8'd4};
    y_in = {7'd5, 7'd10, 7'd6};
    colour_in = {3'd1, 3'd5, 3'd2};
    we_in = 3'b111;
    tick();
    checks++;
    if (x_out !== 8'd165 || y_out !== 7'd10 || writeEn !== 1'b0) begin
      $display("FAIL bounds_out: x=%0d y=%0d we=%b required x=165 y=10 we=0", x_out, y_out, writeEn); errors++;
    end
    x_in[15:8] = 8'd12;
    clear_req = 1'b1;
    tick();
    checks++;
    if (x_out !== 8'd12 || y_out !== 7'd10 || colour !== 3'd5 || writeEn !== 1'b1) begin
      $display("FAIL bounds_in: x=%0d y=%0d col=%0d we=%b required x=12 y=10 col=5 we=1",
               x_out, y_out, colour, writeEn);
      errors++;
    end
    clear_req = 1'b0;
    tick();
    checks++;
    if (clear_busy !== 1'b0 || grant !== 3'b010) begin
      $display("FAIL bounds_clear_ignored: busy=%b grant=%b required 0/010", clear_busy, grant); errors++;
    end
    req = 3'b000;
    we_in = 3'b000;
    tick();
    model_last = 1;
    tick();
    checks++;
    if (clear_busy !== 1'b0 || grant !== 3'b000 || writeEn !== 1'b0) begin
      $display("FAIL bounds_idle: busy=%b grant=%b we=%b required 0/000/0", clear_busy, grant, writeEn); errors++;
    end
  endtask

  // clear_req and req in the same idle cycle: clear first, grant afterwards.
  task automatic test_clear_priority();
    clear_req = 1'b1;
    req = 3'b001;
    tick();
    clear_req = 1'b0;
    checks++;
    if (clear_busy !== 1'b1 || grant !== 3'b000) begin
      $display("FAIL prio_start: busy=%b grant=%b required 1/000", clear_busy, grant); errors++;
    end
    check_sweep("sweep_clear_req");
    checks++;
    if (grant !== 3'b000) begin
      $display("FAIL prio_end_grant: grant=%b required 000", grant); errors++;
    end
    tick();
    checks++;
    if (grant !== 3'b001) begin
      $display("FAIL prio_grant: grant=%b required 001", grant); errors++;
    end
    req = 3'b000;
    tick();
    model_last = 0;
  endtask

  // Reset in the middle of owner 2's burst.
  task automatic test_reset_mid_burst();
    int exp_owner;
    req = 3'b100;
    tick();
    checks++;
    if (grant !== 3'b100) begin
      $display("FAIL rst_burst_grant: grant=%b required 100", grant); errors++;
    end
    repeat (5) tick();
    reset = 1'b1;
    req = 3'b111;
    tick();
    checks++;
    if (grant !== 3'b000 || clear_busy !== 1'b1 || writeEn !== 1'b0) begin
      $display("FAIL rst_burst_reset: grant=%b busy=%b we=%b required 000/1/0", grant, clear_busy, writeEn); errors++;
    end
    reset = 1'b0;
    model_last = 2;
    check_sweep("sweep_after_midreset");
    tick();
    exp_owner = rr_pick(model_last, 3'b111);
    checks++;
    if (grant !== 3'(1 << exp_owner)) begin
      $display("FAIL rst_burst_prio: grant=%b required %b", grant, 3'(1 << exp_owner)); errors++;
    end
    req = 3'b000;
    tick();
    checks++;
    if (grant !== 3'b000) begin
      $display("FAIL rst_burst_release: grant=%b required 000", grant); errors++;
    end
    model_last = exp_owner;
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_round_robin();
    test_random_pixels();
    test_bounds();
    test_clear_priority();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_write_arbiter.md
VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, visible pixel columns.
REQ-002 SHALL have parameter SCREEN_H, default 120, visible pixel rows.
REQ-003 SHALL have parameter MAX_BURST, default 432, maximum grant length in cycles (3 glyphs x 144 pixels).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  3  per-requester bus request, level-held for the whole burst.
REQ-007 SHALL have port x_in  input  24  requester x coordinates; requester i uses bits [8i+7:8i].
REQ-008 SHALL have port y_in  input  21  requester y coordinates; requester i uses bits [7i+6:7i].
REQ-009 SHALL have port colour_in  input  9  requester colours; requester i uses bits [3i+2:3i].
REQ-010 SHALL have port we_in  input  3  per-requester pixel write strobe.
REQ-011 SHALL have port clear_req  input  1  request a full-screen clear to colour 000.
REQ-012 SHALL have port grant  output  3  one-hot registered grant; all zero when no requester owns the port.
REQ-013 SHALL have port x_out  output  8  pixel x to the VGA adapter.
REQ-014 SHALL have port y_out  output  7  pixel y to the VGA adapter.
REQ-015 SHALL have port colour  output  3  pixel colour to the VGA adapter.
REQ-016 SHALL have port writeEn  output  1  pixel write enable to the VGA adapter.
REQ-017 SHALL have port clear_busy  output  1  high while the internal clear sweep runs.

Function
REQ-018 SHALL implement the states S_CLEAR, S_IDLE and S_GRANT; all outputs SHALL be registered.
REQ-019 SHALL, in S_CLEAR, output one pixel per cycle with colour 000 and writeEn=1, raster order x 0..SCREEN_W-1 then y 0..SCREEN_H-1, and hold clear_busy=1 and grant=000.
REQ-020 SHALL, in S_CLEAR, enter S_IDLE on the edge after pixel (SCREEN_W-1, SCREEN_H-1) is issued, giving exactly SCREEN_W*SCREEN_H consecutive writeEn cycles.
REQ-021 SHALL, in S_IDLE, drive writeEn=0, hold x_out/y_out/colour at 0, and hold grant=000.
REQ-022 SHALL, in S_IDLE with clear_req=1, enter S_CLEAR; clear_req SHALL win over any req asserted in the same cycle.
REQ-023 SHALL ignore clear_req outside S_IDLE (it is not latched).
REQ-024 SHALL, in S_IDLE with clear_req=0 and req!=0, select a requester round-robin starting from (last_owner+1) mod 3, drive the one-hot grant on the next edge, and enter S_GRANT.
REQ-025 SHALL reset last_owner to 2, so requester 0 has top priority after reset.
REQ-026 SHALL, in S_GRANT for owner g, register the outputs each cycle as x_out=x_in[g], y_out=y_in[g], colour=colour_in[g], writeEn=we_in[g] & req[g] & in_bounds, giving a latency of 1 cycle from input to output.
REQ-027 SHALL define in_bounds as (x < SCREEN_W) and (y < SCREEN_H); out-of-bounds pixels SHALL still drive x_out/y_out but with writeEn=0.
REQ-028 SHALL ignore we_in, x_in, y_in and colour_in of non-granted requesters.
REQ-029 SHALL, when req[g] drops in S_GRANT, clear grant on the next edge, set last_owner=g, and return to S_IDLE.
REQ-030 SHALL leave at least one S_IDLE cycle (grant=000) between consecutive owners.
REQ-031 SHALL count granted cycles; when the count reaches MAX_BURST with req[g] still high, revoke grant on that edge, set last_owner=g, and enter S_IDLE (preemption).
REQ-032 SHALL let a preempted requester that keeps req high be regranted only through normal round-robin order.
REQ-033 SHALL reset the burst counter on every entry to S_GRANT.

Reset
REQ-034 SHALL, on reset=1 in any state, set grant=000, writeEn=0, x_out=0, y_out=0, colour=000, clear_busy=1, last_owner=2, clear counters 0, and state S_CLEAR.
REQ-035 SHALL start the clear sweep at pixel (0,0) in the first cycle after reset deasserts, including when reset arrives mid-burst or mid-clear.

Verification
REQ-036 SHALL cover: release reset -> 19200 consecutive writeEn=1 cycles, colour 000, first (0,0), last (159,119), then clear_busy=0.
REQ-037 SHALL cover: req=111 held constantly after the clear -> grants in the order 001, 010, 100, 001, each lasting 432 cycles, with one idle cycle between grants.
REQ-038 SHALL cover: owner 1 drives x=165, y=10 with we=1 -> x_out=165, writeEn=0; then x=12, y=10 -> writeEn=1 one cycle later.
REQ-039 SHALL cover: clear_req=1 and req=001 in the same S_IDLE cycle -> clear sweep first, grant=001 only after 19200 cycles.
REQ-040 SHALL cover: reset pulsed during grant=100 -> grant=000 on the next cycle, then a full clear from (0,0), then requester 0 has priority.
